// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter sharing one uart_tx Avalon-MM slave among
// RN requesters. One whole transfer is forwarded at a time from the granted
// requester; everyone else is held off with waitrequest.
// Optional feature macro: UART_TX_ARB_LOCK_EN. When defined, the grant is
// kept in a HOLD state after each non-newline write so text lines from
// different sources never interleave. A held lock is released after LOCK_TMO
// idle cycles.
module uart_tx_arb #(
  parameter int RN       = 2,
  parameter int AAW      = 1,
  parameter int ADW      = 32,
  parameter int ABW      = ADW / 8,
  parameter int LOCK_TMO = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RN-1:0]     req_read,
  input  logic [RN-1:0]     req_write,
  input  logic [RN*AAW-1:0] req_address,
  input  logic [RN*ABW-1:0] req_byteenable,
  input  logic [RN*ADW-1:0] req_writedata,
  output logic [ADW-1:0]    req_readdata,
  output logic [RN-1:0]     req_waitrequest,
  output logic              avalon_read,
  output logic              avalon_write,
  output logic [AAW-1:0]    avalon_address,
  output logic [ABW-1:0]    avalon_byteenable,
  output logic [ADW-1:0]    avalon_writedata,
  input  logic [ADW-1:0]    avalon_readdata,
  input  logic              avalon_waitrequest,
  output logic [RN-1:0]     grant
);

  localparam int PW = (RN > 1) ? $clog2(RN) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1
`ifdef UART_TX_ARB_LOCK_EN
    , ST_HOLD = 2'd2
`endif
  } state_t;

  // Reject configurations the rotating search and the lock counter cannot handle.
  generate
    if (RN < 2 || RN > 8 || LOCK_TMO < 1 || LOCK_TMO > 1023) begin : g_bad_param
      $error("uart_tx_arb: parameter out of range");
    end
  endgenerate

  state_t          state_r, state_s;
  logic [PW-1:0]   ptr_r, ptr_s;
  logic [PW-1:0]   gidx_r, gidx_s;
  logic [RN-1:0]   grant_r, grant_s;
  logic [RN-1:0]   active_s;
  logic            found_s;
  logic [PW-1:0]   pick_s;
  logic            g_read_s, g_write_s;
  logic [AAW-1:0]  g_addr_s;
  logic [ABW-1:0]  g_be_s;
  logic [ADW-1:0]  g_wd_s;
  logic            done_s;

`ifdef UART_TX_ARB_LOCK_EN
  localparam logic [9:0] LOCK_TMO_C = 10'(LOCK_TMO);
  logic [9:0] lock_cnt_r, lock_cnt_s;
`endif

  assign active_s     = req_read | req_write;
  assign req_readdata = avalon_readdata;
  assign grant        = grant_r;

  // Select the granted requester's signals (only meaningful in BUSY).
  always_comb begin
    g_read_s  = req_read[gidx_r];
    g_write_s = req_write[gidx_r];
    g_addr_s  = req_address[int'(gidx_r)*AAW +: AAW];
    g_be_s    = req_byteenable[int'(gidx_r)*ABW +: ABW];
    g_wd_s    = req_writedata[int'(gidx_r)*ADW +: ADW];
  end

  assign done_s = (state_r == ST_BUSY) & (g_read_s | g_write_s) & ~avalon_waitrequest;

  // Rotating-priority search: first active requester upward from ptr+1.
  always_comb begin
    int idx_v;
    idx_v   = 0;
    found_s = 1'b0;
    pick_s  = ptr_r;
    for (int k = 1; k <= RN; k++) begin
      idx_v = (int'(ptr_r) + k) % RN;
      if (!found_s && active_s[idx_v]) begin
        found_s = 1'b1;
        pick_s  = PW'(idx_v);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next-state, next-pointer and next-grant logic.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    gidx_s  = gidx_r;
    grant_s = grant_r;
`ifdef UART_TX_ARB_LOCK_EN
    lock_cnt_s = lock_cnt_r;
`endif
    case (state_r)
      ST_IDLE: begin
        grant_s = {RN{1'b0}};
        if (found_s) begin
          state_s = ST_BUSY;
          gidx_s  = pick_s;
          grant_s = {{(RN-1){1'b0}}, 1'b1} << pick_s;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (done_s) begin
          ptr_s = gidx_r;
`ifdef UART_TX_ARB_LOCK_EN
          if (g_write_s && (g_wd_s[7:0] != 8'h0a)) begin
            state_s    = ST_HOLD;
            lock_cnt_s = 10'd0;
          end else begin
            state_s = ST_IDLE;
            grant_s = {RN{1'b0}};
          end
`else
          state_s = ST_IDLE;
          grant_s = {RN{1'b0}};
`endif
        end else if (!(g_read_s | g_write_s)) begin
          // Request withdrawn mid-transfer: abandon it, priority unchanged.
          state_s = ST_IDLE;
          grant_s = {RN{1'b0}};
        end else begin
          state_s = ST_BUSY;
        end
      end
`ifdef UART_TX_ARB_LOCK_EN
      ST_HOLD: begin
        if (active_s[gidx_r]) begin
          state_s    = ST_BUSY;
          lock_cnt_s = 10'd0;
        end else if ((lock_cnt_r + 10'd1) == LOCK_TMO_C) begin
          state_s    = ST_IDLE;
          grant_s    = {RN{1'b0}};
          ptr_s      = gidx_r;
          lock_cnt_s = 10'd0;
        end else begin
          lock_cnt_s = lock_cnt_r + 10'd1;
        end
      end
`endif
      default: begin
        state_s = ST_IDLE;
        grant_s = {RN{1'b0}};
      end
    endcase
  end

  // Master port mux and per-requester waitrequest routing.
  always_comb begin
    avalon_read       = 1'b0;
    avalon_write      = 1'b0;
    avalon_address    = {AAW{1'b0}};
    avalon_byteenable = {ABW{1'b0}};
    avalon_writedata  = {ADW{1'b0}};
    req_waitrequest   = {RN{1'b1}};
    if (state_r == ST_BUSY) begin
      avalon_read             = g_read_s;
      avalon_write            = g_write_s;
      avalon_address          = g_addr_s;
      avalon_byteenable       = g_be_s;
      avalon_writedata        = g_wd_s;
      req_waitrequest[gidx_r] = avalon_waitrequest;
    end else begin
      req_waitrequest = {RN{1'b1}};
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      ptr_r   <= PW'(RN - 1);
      gidx_r  <= {PW{1'b0}};
      grant_r <= {RN{1'b0}};
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      gidx_r  <= gidx_s;
      grant_r <= grant_s;
    end
  end

`ifdef UART_TX_ARB_LOCK_EN
  // Idle-cycle counter for releasing a held lock.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lock_cnt_r <= 10'd0;
    end else begin
      lock_cnt_r <= lock_cnt_s;
    end
  end
`endif

endmodule
